// File: rtl/midi_pkg.sv
// MIDI status-byte constants and decode helpers shared by the
// message transmitter and its UART byte serialiser.
package midi_pkg;

    localparam logic [7:0] ST_SYS_BASE = 8'hF0;
    localparam logic [7:0] ST_RT_BASE  = 8'hF8;
    localparam logic [7:0] ST_NONE     = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        S_STAT,
        S_D1,
        S_D2
    } msg_state_t;

    // 0 marks a status byte this block will not transmit
    function automatic logic [1:0] midi_len(input logic [7:0] s);
        logic [1:0] n;
        casez (s)
            8'b0???????: n = 2'd0;
            8'b10??????: n = 2'd3;
            8'b110?????: n = 2'd2;
            8'b1110????: n = 2'd3;
            8'hF2:       n = 2'd3;
            8'hF1:       n = 2'd2;
            8'hF3:       n = 2'd2;
            8'hF6:       n = 2'd1;
            8'hF8:       n = 2'd1;
            8'hFA:       n = 2'd1;
            8'hFB:       n = 2'd1;
            8'hFC:       n = 2'd1;
            8'hFE:       n = 2'd1;
            8'hFF:       n = 2'd1;
            default:     n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic is_channel(input logic [7:0] s);
        return s[7] && (s[6:4] != 3'b111);
    endfunction

    function automatic logic is_realtime(input logic [7:0] s);
        return s >= ST_RT_BASE;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serialiser: one byte per start pulse, done marks the last
// stop-bit cycle so a following byte can start without a gap.
module uart_tx_byte #(
    parameter int BAUD_DIV = 320
) (
    input  logic       SYSCLK,
    input  logic       SYSRESET,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       txd
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;
    logic [3:0]    bitn;
    logic [8:0]    shreg;
    logic          tick;

    assign tick = (cnt == CNT_LAST);
    assign done = busy && tick && (bitn == 4'd9);

    // shreg carries data plus the stop bit; the start bit is driven directly
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            busy  <= 1'b0;
            txd   <= 1'b1;
            cnt   <= '0;
            bitn  <= '0;
            shreg <= '1;
        end else if (start) begin
            busy  <= 1'b1;
            txd   <= 1'b0;
            cnt   <= '0;
            bitn  <= '0;
            shreg <= {1'b1, data};
        end else if (busy) begin
            if (tick) begin
                cnt <= '0;
                if (bitn == 4'd9) begin
                    busy <= 1'b0;
                end else begin
                    bitn  <= bitn + 4'd1;
                    txd   <= shreg[0];
                    shreg <= {1'b1, shreg[8:1]};
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_msg_tx.sv
// MIDI message transmitter: length decode, running-status suppression
// and byte sequencing onto a single UART line.
module midi_msg_tx
    import midi_pkg::*;
#(
    parameter int BAUD_DIV       = 320,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic       SYSCLK,
    input  logic       SYSRESET,
    input  logic       MSG_VALID,
    output logic       MSG_READY,
    input  logic [7:0] STATUS,
    input  logic [7:0] DATA1,
    input  logic [7:0] DATA2,
    output logic       MIDI_TX,
    output logic       BUSY,
    output logic       MSG_ERR
);

    msg_state_t state;
    logic       ready_q;
    logic [1:0] len_q;
    logic [6:0] d1_q;
    logic [6:0] d2_q;
    logic [7:0] last_status;

    logic       u_start;
    logic       u_busy;
    logic       u_done;
    logic [7:0] u_data;

    logic       accept;
    logic [1:0] len_in;
    logic       skip;
    logic       unused_bits;

    assign len_in      = midi_len(STATUS);
    assign skip        = RUNNING_STATUS && is_channel(STATUS)
                         && (STATUS == last_status);
    assign MSG_READY   = ready_q && !u_busy && !SYSRESET;
    assign accept      = MSG_VALID && MSG_READY;
    assign unused_bits = ^{DATA1[7], DATA2[7]};

    // first byte leaves straight from the inputs so the line falls
    // on the cycle right after the accept edge
    always_comb begin
        u_start = 1'b0;
        u_data  = 8'h00;
        unique case (state)
            IDLE: begin
                if (accept && len_in != 2'd0) begin
                    u_start = 1'b1;
                    u_data  = skip ? {1'b0, DATA1[6:0]} : STATUS;
                end
            end
            S_STAT: begin
                if (u_done && len_q != 2'd1) begin
                    u_start = 1'b1;
                    u_data  = {1'b0, d1_q};
                end
            end
            S_D1: begin
                if (u_done && len_q == 2'd3) begin
                    u_start = 1'b1;
                    u_data  = {1'b0, d2_q};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            BUSY        <= 1'b0;
            MSG_ERR     <= 1'b0;
            last_status <= ST_NONE;
            len_q       <= 2'd0;
            d1_q        <= '0;
            d2_q        <= '0;
        end else begin
            MSG_ERR <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && len_in == 2'd0) begin
                        MSG_ERR <= 1'b1;
                    end else if (accept) begin
                        ready_q <= 1'b0;
                        BUSY    <= 1'b1;
                        len_q   <= len_in;
                        d1_q    <= DATA1[6:0];
                        d2_q    <= DATA2[6:0];
                        state   <= skip ? S_D1 : S_STAT;
                        if (is_channel(STATUS))
                            last_status <= STATUS;
                        else if (!is_realtime(STATUS))
                            last_status <= ST_NONE;
                    end
                end
                S_STAT: begin
                    if (u_done && len_q == 2'd1) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        BUSY    <= 1'b0;
                    end else if (u_done) begin
                        state <= S_D1;
                    end
                end
                S_D1: begin
                    if (u_done && len_q == 2'd3) begin
                        state <= S_D2;
                    end else if (u_done) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        BUSY    <= 1'b0;
                    end
                end
                S_D2: begin
                    if (u_done) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        BUSY    <= 1'b0;
                    end
                end
            endcase
        end
    end

    uart_tx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .SYSCLK  (SYSCLK),
        .SYSRESET(SYSRESET),
        .start   (u_start),
        .data    (u_data),
        .busy    (u_busy),
        .done    (u_done),
        .txd     (MIDI_TX)
    );

endmodule

// File: tb/tb_midi_msg_tx.sv
// Bench for midi_msg_tx: a fast running-status instance and a
// full-rate instance without running status, with a UART decoder.
module tb_midi_msg_tx;

    typedef struct {
        logic [7:0] s;
        logic [7:0] a;
        logic [7:0] b;
        int         nb;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       hold;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] status;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] valid;
    logic [1:0] rdy;
    logic [1:0] tx;
    logic [1:0] bsy;
    logic [1:0] err;

    int nvec;
    int nfail;
    int dv[2];

    logic [7:0] q[2][$];
    logic       mact[2];
    int         mk[2];
    logic [7:0] msh[2];

    vec_t tv[16];
    vec_t tv1[2];

    midi_msg_tx #(.BAUD_DIV(16), .RUNNING_STATUS(1'b1)) dut0 (
        .SYSCLK   (clk),
        .SYSRESET (rst),
        .MSG_VALID(valid[0]),
        .MSG_READY(rdy[0]),
        .STATUS   (status),
        .DATA1    (d1),
        .DATA2    (d2),
        .MIDI_TX  (tx[0]),
        .BUSY     (bsy[0]),
        .MSG_ERR  (err[0])
    );

    midi_msg_tx #(.BAUD_DIV(320), .RUNNING_STATUS(1'b0)) dut1 (
        .SYSCLK   (clk),
        .SYSRESET (rst),
        .MSG_VALID(valid[1]),
        .MSG_READY(rdy[1]),
        .STATUS   (status),
        .DATA1    (d1),
        .DATA2    (d2),
        .MIDI_TX  (tx[1]),
        .BUSY     (bsy[1]),
        .MSG_ERR  (err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic expire(input string nm);
        nvec++;
        nfail++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    // UART decoder: samples mid-bit, compares each byte to the scoreboard
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mact[i] = 1'b0;
            end else if (!mact[i]) begin
                if (tx[i] == 1'b0) begin
                    mact[i] = 1'b1;
                    mk[i]   = 0;
                end
            end else begin
                mk[i]++;
                if (mk[i] >= dv[i] / 2
                    && (mk[i] - dv[i] / 2) % dv[i] == 0) begin
                    int j;
                    j = (mk[i] - dv[i] / 2) / dv[i];
                    if (j == 0) begin
                        chk("start_bit", {31'd0, tx[i]}, 32'd0);
                    end else if (j <= 8) begin
                        msh[i] = {tx[i], msh[i][7:1]};
                    end else begin
                        chk("stop_bit", {31'd0, tx[i]}, 32'd1);
                        if (q[i].size() == 0) begin
                            nvec++;
                            nfail++;
                            $display("FAIL unexpected_byte: dut%0d got %0h, none expected",
                                     i, msh[i]);
                        end else begin
                            chk($sformatf("byte_dut%0d", i),
                                {24'd0, msh[i]}, {24'd0, q[i].pop_front()});
                        end
                        mact[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input int i, input vec_t v);
        int t;
        int nmax;
        int cnt;
        t = 0;
        while (rdy[i] !== 1'b1 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) expire("ready_wait");
        status   = v.s;
        d1       = v.a;
        d2       = v.b;
        valid[i] = 1'b1;
        if (v.nb >= 1) q[i].push_back(v.e0);
        if (v.nb >= 2) q[i].push_back(v.e1);
        if (v.nb >= 3) q[i].push_back(v.e2);
        @(negedge clk);
        if (!v.hold) valid[i] = 1'b0;
        chk("err_pulse", {31'd0, err[i]}, {31'd0, v.nb == 0});
        chk("busy_rise", {31'd0, bsy[i]}, {31'd0, v.nb != 0});
        chk("tx_first", {31'd0, tx[i]}, {31'd0, v.nb == 0});
        if (v.nb == 0) begin
            chk("ready_kept", {31'd0, rdy[i]}, 32'd1);
            @(negedge clk);
            chk("err_end", {31'd0, err[i]}, 32'd0);
            chk("tx_idle", {31'd0, tx[i]}, 32'd1);
        end else begin
            nmax = v.nb * 10 * dv[i];
            cnt  = 1;
            while (bsy[i] && cnt <= nmax + 5) begin
                if (v.hold && cnt == 2) begin
                    status = 8'h90;
                    d1     = 8'h11;
                end
                if (v.hold && cnt == nmax - 5) valid[i] = 1'b0;
                @(negedge clk);
                if (bsy[i]) cnt++;
            end
            chk("busy_len", cnt, nmax);
            chk("ready_back", {31'd0, rdy[i]}, 32'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec   = 0;
        nfail  = 0;
        dv[0]  = 16;
        dv[1]  = 320;
        rst    = 1'b1;
        valid  = 2'b00;
        status = 8'h00;
        d1     = 8'h00;
        d2     = 8'h00;

        tv[0]  = '{8'h90, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64, 1'b0};
        tv[1]  = '{8'h90, 8'h40, 8'h00, 2, 8'h40, 8'h00, 8'h00, 1'b0};
        tv[2]  = '{8'hF8, 8'h00, 8'h00, 1, 8'hF8, 8'h00, 8'h00, 1'b0};
        tv[3]  = '{8'h90, 8'h3E, 8'h7F, 2, 8'h3E, 8'h7F, 8'h00, 1'b0};
        tv[4]  = '{8'hF0, 8'h01, 8'h02, 0, 8'h00, 8'h00, 8'h00, 1'b0};
        tv[5]  = '{8'h45, 8'h01, 8'h02, 0, 8'h00, 8'h00, 8'h00, 1'b0};
        tv[6]  = '{8'h90, 8'h41, 8'h10, 2, 8'h41, 8'h10, 8'h00, 1'b0};
        tv[7]  = '{8'hC5, 8'h87, 8'h00, 2, 8'hC5, 8'h07, 8'h00, 1'b1};
        tv[8]  = '{8'hC5, 8'h08, 8'h00, 1, 8'h08, 8'h00, 8'h00, 1'b0};
        tv[9]  = '{8'hF2, 8'h01, 8'h02, 3, 8'hF2, 8'h01, 8'h02, 1'b0};
        tv[10] = '{8'hC5, 8'h09, 8'h00, 2, 8'hC5, 8'h09, 8'h00, 1'b0};
        tv[11] = '{8'hE0, 8'h00, 8'hC0, 3, 8'hE0, 8'h00, 8'h40, 1'b0};
        tv[12] = '{8'hF6, 8'h00, 8'h00, 1, 8'hF6, 8'h00, 8'h00, 1'b0};
        tv[13] = '{8'hE0, 8'h11, 8'h22, 3, 8'hE0, 8'h11, 8'h22, 1'b0};
        tv[14] = '{8'hFD, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1'b0};
        tv[15] = '{8'hF3, 8'h05, 8'h00, 2, 8'hF3, 8'h05, 8'h00, 1'b0};

        tv1[0] = '{8'h90, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64, 1'b0};
        tv1[1] = '{8'h90, 8'h40, 8'h00, 3, 8'h90, 8'h40, 8'h00, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", {31'd0, tx[0]}, 32'd1);
        chk("reset_ready", {31'd0, rdy[0]}, 32'd1);
        chk("reset_busy", {31'd0, bsy[0]}, 32'd0);
        chk("reset_err", {31'd0, err[0]}, 32'd0);

        for (int k = 0; k < 16; k++) send(0, tv[k]);

        // reset in the middle of the second byte of a full message
        status   = 8'h90;
        d1       = 8'h3C;
        d2       = 8'h64;
        valid[0] = 1'b1;
        q[0].push_back(8'h90);
        q[0].push_back(8'h3C);
        q[0].push_back(8'h64);
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (240) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", {31'd0, tx[0]}, 32'd1);
        chk("midrst_busy", {31'd0, bsy[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, rdy[0]}, 32'd1);
        chk("midrst_qlen", q[0].size(), 32'd2);
        q[0].delete();
        @(negedge clk);
        send(0, tv[0]);

        send(1, tv1[0]);
        send(1, tv1[1]);

        repeat (20) @(negedge clk);
        chk("drain_dut0", q[0].size(), 32'd0);
        chk("drain_dut1", q[1].size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
